// File: rtl/rc_servo_pkg.sv
// Shared channel state type and reading-to-pulse-width scaling for the RC servo core.
package rc_servo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHARGE,
    DONE
  } chan_state_e;

  // MIN + (reading*(MAX-MIN))>>meas_w, clamped to MAX; 64-bit product cannot overflow
  function automatic int unsigned scale_width(input int unsigned reading,
                                              input int unsigned min_p,
                                              input int unsigned max_p,
                                              input int unsigned meas_w);
    logic [63:0] prod;
    logic [63:0] w;
    prod = 64'(reading) * 64'(max_p - min_p);
    w    = 64'(min_p) + (prod >> meas_w);
    if (w > 64'(max_p)) w = 64'(max_p);
    return w[31:0];
  endfunction

endpackage

// File: rtl/rc_servo_chan.sv
// One servo channel: comparator synchroniser, RC charge-time FSM, frame-aligned width
// register with optional slew limit, and registered PWM compare against the shared counter.
module rc_servo_chan
  import rc_servo_pkg::*;
#(
  parameter int unsigned MEAS_W      = 10,
  parameter int unsigned MIN_PULSE   = 1000,
  parameter int unsigned MAX_PULSE   = 2000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SLEW_STEP   = 16,
  parameter int unsigned CNT_W       = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              comp_async_i,
  input  logic [CNT_W-1:0]  frame_cnt_i,
  output logic              chg_o,
  output logic              pwm_o,
  output logic              meas_valid_o,
  output logic [MEAS_W-1:0] meas_o,
  output logic              timeout_o
);

  localparam int unsigned      WIDTH_W = $clog2(MAX_PULSE + 1);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'((1 << MEAS_W) - 1);
  localparam logic [WIDTH_W-1:0] MIN_W = WIDTH_W'(MIN_PULSE);

  logic [SYNC_STAGES-1:0] sync_q;
  chan_state_e            state_q;
  logic                   chg_q, pwm_q, vld_q, tmo_q;
  logic [MEAS_W-1:0]      meas_q;
  logic [WIDTH_W-1:0]     width_q, pend_q, width_d, pend_d;
  logic [MEAS_W-1:0]      rd_d;
  logic                   at_zero, at_tmo, trip, charging, done;

  assign at_zero  = (frame_cnt_i == '0);
  assign at_tmo   = (frame_cnt_i == TMO_CNT);
  assign trip     = sync_q[SYNC_STAGES-1];
  // frame_cnt==0 counts as a charge cycle so an undischarged cap reads 0
  assign charging = at_zero || (state_q == CHARGE);
  assign done     = charging && (trip || at_tmo);
  assign rd_d     = trip ? frame_cnt_i[MEAS_W-1:0] : '1;
  assign pend_d   = WIDTH_W'(scale_width(32'(rd_d), MIN_PULSE, MAX_PULSE, MEAS_W));

  logic [WIDTH_W:0] w_x, p_x, s_x;

  always_comb begin
    w_x     = {1'b0, width_q};
    p_x     = {1'b0, pend_q};
    s_x     = (WIDTH_W + 1)'(SLEW_STEP);
    width_d = pend_q;
    if (p_x > w_x + s_x)      width_d = width_q + s_x[WIDTH_W-1:0];
    else if (w_x > p_x + s_x) width_d = width_q - s_x[WIDTH_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q  <= '0;
      state_q <= IDLE;
      chg_q   <= 1'b0;
      pwm_q   <= 1'b0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
      meas_q  <= '0;
      pend_q  <= MIN_W;
      width_q <= MIN_W;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], comp_async_i};
      vld_q  <= 1'b0;
      if (!enable_i) begin
        state_q <= IDLE;
        chg_q   <= 1'b0;
        pwm_q   <= 1'b0;
        tmo_q   <= 1'b0;
      end else begin
        pwm_q <= (frame_cnt_i < CNT_W'(width_q));
        if (at_zero) width_q <= width_d;
        if (done) begin
          state_q <= DONE;
          chg_q   <= 1'b0;
          vld_q   <= 1'b1;
          tmo_q   <= !trip;
          meas_q  <= rd_d;
          pend_q  <= pend_d;
        end else if (charging) begin
          state_q <= CHARGE;
          chg_q   <= 1'b1;
        end
      end
    end
  end

  assign chg_o        = chg_q;
  assign pwm_o        = pwm_q;
  assign meas_valid_o = vld_q;
  assign meas_o       = meas_q;
  assign timeout_o    = tmo_q;

endmodule

// File: rtl/rc_servo_core_multi.sv
// N-channel RC-ADC servo core: shared frame counter plus one rc_servo_chan per channel.
// Define RC_SERVO_SLEW_LIMIT_EN to limit per-frame width change to SLEW_STEP.
module rc_servo_core_multi
  import rc_servo_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned FRAME_CYCLES = 20000,
  parameter int unsigned MIN_PULSE    = 1000,
  parameter int unsigned MAX_PULSE    = 2000,
  parameter int unsigned MEAS_W       = 10,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SLEW_STEP    = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic [NUM_CH-1:0]        comp_async_i,
  output logic [NUM_CH-1:0]        chg_o,
  output logic [NUM_CH-1:0]        pwm_o,
  output logic                     frame_o,
  output logic [NUM_CH-1:0]        meas_valid_o,
  output logic [NUM_CH*MEAS_W-1:0] meas_o,
  output logic [NUM_CH-1:0]        timeout_o
);

  localparam int unsigned      CNT_W    = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

`ifdef RC_SERVO_SLEW_LIMIT_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif
  // A step of the full pulse range always snaps, i.e. an unlimited load
  localparam int unsigned STEP_EFF = SLEW_EN ? SLEW_STEP : (MAX_PULSE - MIN_PULSE);

  if (!(MIN_PULSE < MAX_PULSE && MAX_PULSE < FRAME_CYCLES)) begin : g_bad_pulse
    $error("rc_servo_core_multi: need MIN_PULSE < MAX_PULSE < FRAME_CYCLES");
  end
  if (2 * (1 << MEAS_W) > FRAME_CYCLES) begin : g_bad_frame
    $error("rc_servo_core_multi: need 2*(2**MEAS_W) <= FRAME_CYCLES");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rc_servo_core_multi: SYNC_STAGES must be >= 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_q;

  assign cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i || !enable_i) begin
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= (cnt_q == '0);
    end
  end

  assign frame_o = frame_q;

  logic [NUM_CH-1:0][MEAS_W-1:0] meas_w;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rc_servo_chan #(
      .MEAS_W      (MEAS_W),
      .MIN_PULSE   (MIN_PULSE),
      .MAX_PULSE   (MAX_PULSE),
      .SYNC_STAGES (SYNC_STAGES),
      .SLEW_STEP   (STEP_EFF),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .enable_i     (enable_i),
      .comp_async_i (comp_async_i[c]),
      .frame_cnt_i  (cnt_q),
      .chg_o        (chg_o[c]),
      .pwm_o        (pwm_o[c]),
      .meas_valid_o (meas_valid_o[c]),
      .meas_o       (meas_w[c]),
      .timeout_o    (timeout_o[c])
    );
  end

  assign meas_o = meas_w;

endmodule

// File: tb/tb_rc_servo_core_multi.sv
// Directed bench for rc_servo_core_multi (2 ch, 4096-cycle frame, width = 256 + reading).
module tb_rc_servo_core_multi;

  localparam int FRAME = 4096;
  localparam int MINP  = 256;

  logic        clk = 1'b0;
  logic        reset_i, enable_i;
  logic [1:0]  comp;
  logic [1:0]  chg, pwm, vld, tmo;
  logic        frame;
  logic [15:0] meas;

  int checks   = 0;
  int failures = 0;
  int w_m[2];
  int p_m[2];

  always #5 clk = ~clk;

  rc_servo_core_multi #(
    .NUM_CH(2), .FRAME_CYCLES(4096), .MIN_PULSE(256), .MAX_PULSE(512),
    .MEAS_W(8), .SYNC_STAGES(2), .SLEW_STEP(16)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .comp_async_i (comp),
    .chg_o        (chg),
    .pwm_o        (pwm),
    .frame_o      (frame),
    .meas_valid_o (vld),
    .meas_o       (meas),
    .timeout_o    (tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Width loaded at a frame boundary, given current width and pending target
  function automatic int next_w(input int cur, input int pend);
`ifdef RC_SERVO_SLEW_LIMIT_EN
    if (pend > cur + 16) return cur + 16;
    if (cur > pend + 16) return cur - 16;
`endif
    return pend;
  endfunction

  task automatic chk_idle(input string tag, input logic [15:0] meas_exp);
    chk({tag, " pwm"},   32'(pwm),   0);
    chk({tag, " chg"},   32'(chg),   0);
    chk({tag, " frame"}, 32'(frame), 0);
    chk({tag, " vld"},   32'(vld),   0);
    chk({tag, " tmo"},   32'(tmo),   0);
    chk({tag, " meas"},  32'(meas),  32'(meas_exp));
  endtask

  // Runs one full frame starting at output time 0. Comparator edges are driven
  // after sampling output time t; a rise at t=T-3 trips the FSM at frame_cnt=T.
  task automatic run_frame(input string tag, input int rise0, input int fall0,
                           input int rise1, input int fall1, input int rd0, input int rd1,
                           input bit to0, input bit to1);
    int pw[2], cg[2], vn[2], vt[2], rd[2];
    bit to[2];
    int fn, ft;
    rd[0] = rd0; rd[1] = rd1; to[0] = to0; to[1] = to1;
    fn = 0; ft = -1;
    for (int c = 0; c < 2; c++) begin
      w_m[c] = next_w(w_m[c], p_m[c]);
      pw[c] = 0; cg[c] = 0; vn[c] = 0; vt[c] = -1;
    end
    for (int t = 0; t < FRAME; t++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (pwm[c] === 1'b1) pw[c]++;
        if (chg[c] === 1'b1) cg[c]++;
        if (vld[c] === 1'b1) begin vn[c]++; vt[c] = t; end
      end
      if (frame === 1'b1) begin fn++; ft = t; end
      if (t == rise0) comp[0] = 1'b1;
      if (t == fall0) comp[0] = 1'b0;
      if (t == rise1) comp[1] = 1'b1;
      if (t == fall1) comp[1] = 1'b0;
    end
    chk({tag, " frame_n"}, 32'(fn), 1);
    chk({tag, " frame_t"}, 32'(ft), 0);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("%s pwm_w%0d", tag, c),  32'(pw[c]), 32'(w_m[c]));
      chk($sformatf("%s chg_n%0d", tag, c),  32'(cg[c]), 32'(rd[c]));
      chk($sformatf("%s vld_n%0d", tag, c),  32'(vn[c]), 1);
      chk($sformatf("%s vld_t%0d", tag, c),  32'(vt[c]), 32'(rd[c]));
      chk($sformatf("%s meas%0d", tag, c),   32'(meas[c*8 +: 8]), 32'(rd[c]));
      chk($sformatf("%s tmo%0d", tag, c),    32'(tmo[c]), 32'(to[c]));
      p_m[c] = MINP + rd[c];
    end
  endtask

  initial begin
    reset_i  = 1'b1;
    enable_i = 1'b1;
    comp     = 2'b00;
    repeat (3) @(negedge clk);
    chk_idle("reset", 16'h0000);

    reset_i  = 1'b0;
    enable_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("idle", 16'h0000);

    enable_i = 1'b1;
    w_m = '{MINP, MINP};
    p_m = '{MINP, MINP};
    run_frame("A", 97,   600, 37, 600, 100, 40,  1'b0, 1'b0);
    run_frame("B", 97,   600, -1, -1,  100, 255, 1'b0, 1'b1);
    run_frame("C", 4000, -1,  47, 600, 255, 50,  1'b1, 1'b0);
    run_frame("D", -1,   600, 17, 600, 0,   20,  1'b0, 1'b0);

    // Reset lands at frame_cnt=50 with both channels still charging
    for (int t = 0; t < 50; t++) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    chk_idle("rst_mid", 16'h0000);
    @(negedge clk);
    reset_i = 1'b0;
    w_m = '{MINP, MINP};
    p_m = '{MINP, MINP};
    run_frame("F", 97, 600, 37, 600, 100, 40, 1'b0, 1'b0);
    run_frame("G", -1, -1,  37, 600, 255, 40, 1'b1, 1'b0);
    run_frame("H", -1, -1,  37, 600, 255, 40, 1'b1, 1'b0);
    run_frame("I", -1, -1,  37, 600, 255, 40, 1'b1, 1'b0);

    // Disable keeps the last readings but silences every other output
    enable_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("disable", 16'h28FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
